fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and fetch-sequencing stage that drives the instruction memory's word address and delivers each fetched instruction, tagged with its PC, to decode. It absorbs the memory's one-cycle synchronous read latency and supports decode stalls and zero-bubble branch/jump redirects. It also detects misaligned and out-of-range fetches and counts delivered instructions.

## Interface
- RESET_PC, 32'h0000_0000, byte address of the first instruction; must be word-aligned
- MEM_WORDS, 128, instruction memory depth in words; word index ≥ MEM_WORDS is out of range
- clk  in  1  rising-edge clock, shared with instruction memory
- reset  in  1  synchronous, active-high
- stall  in  1  decode cannot accept; hold current instruction
- redirect  in  1  current instruction is a taken branch/jump
- redirect_pc  in  32  byte target for redirect
- imem_addr  out  32  word address to memory, {2'b00, sel_pc[31:2]}; combinational
- imem_instr  in  32  memory read data, valid one cycle after address sampled
- instr  out  32  instruction to decode; 32'h0 when instr_valid=0
- instr_pc  out  32  byte PC of instr
- pc_plus4  out  32  instr_pc + 4, modulo 2^32
- instr_valid  out  1  instr/instr_pc meaningful
- fault  out  1  sticky fetch fault
- fault_pc  out  32  offending byte address
- fetch_count  out  32  instructions consumed by decode

## Operation
- Registers: f_pc (next PC to present), d_pc (PC of word on imem_instr), state ∈ {FILL, RUN, FAULT}, fault_pc, fetch_count.
- instr_valid = (state==RUN); instr_pc = d_pc; instr = instr_valid ? imem_instr : 0.
- sel_pc (drives imem_addr), priority order:
  - FILL: f_pc.
  - RUN and redirect: redirect_pc.
  - RUN and stall: d_pc (memory re-reads same word, so instr stays stable).
  - RUN otherwise: f_pc.
  - FAULT: d_pc.
- Transitions on each clk edge, reset=0:
  - FILL → RUN: d_pc←f_pc, f_pc←f_pc+4. If f_pc out of range → FAULT, fault_pc←f_pc.
  - RUN, redirect=1: if redirect_pc[1:0]≠0 or word index ≥ MEM_WORDS → FAULT, fault_pc←redirect_pc. Otherwise d_pc←redirect_pc, f_pc←redirect_pc+4. fetch_count+1 in both cases; stall is ignored.
  - RUN, stall=1, redirect=0: hold all registers; fetch_count unchanged.
  - RUN, neither: if f_pc out of range → FAULT, fault_pc←f_pc. Otherwise d_pc←f_pc, f_pc←f_pc+4. fetch_count+1 in both cases.
  - FAULT: absorbing until reset. stall/redirect ignored.
- fault = (state==FAULT).
- fetch_count wraps 2^32−1 → 0.
- The instruction displayed in a redirect cycle is consumed; the sequential successor is never delivered.

## Timing
- Reset (any cycle, including mid-stall or FAULT) → next edge:
  - state=FILL, f_pc=d_pc=RESET_PC, fault_pc=0, fetch_count=0.
  - Outputs: instr_valid=0, instr=0, instr_pc=RESET_PC, pc_plus4=RESET_PC+4, fault=0, imem_addr=RESET_PC>>2.
- First valid instruction: second cycle after reset falls (one FILL cycle).
- Steady state: one instruction per cycle; instr_pc advances by 4 each edge without stall.
- Redirect penalty: zero bubbles; target instruction valid in the cycle after redirect.
- Stall: instr/instr_pc bit-stable for the stall duration; resumes with f_pc on release.
- Fault: instr_valid falls and fault rises in the cycle after the offending edge.

## Test plan
- Reset release with RESET_PC=0 and memory words 0..5 loaded → cycle 1 instr_valid=0; cycles 2–7 instr_pc=0,4,…,20 with matching words; fetch_count=6 after cycle 7.
- stall held 3 cycles while instr_pc=8 → instr_pc=8 and instr=Memory[2] for 4 cycles; fetch_count frozen; next instr_pc=12.
- redirect=1, redirect_pc=0x40 while instr_pc=4 → next cycle instr_pc=0x40, instr=Memory[16]; PC 8 never valid; redirect+stall together behaves identically.
- redirect_pc=0x42 → next cycle fault=1, fault_pc=0x42, instr_valid=0, instr=0; persists through stall/redirect until reset.
- Sequential run to instr_pc=0x1FC with MEM_WORDS=128 → next edge fault=1, fault_pc=0x200.
- Reset asserted mid-stall and in FAULT → all outputs return to reset values next edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC/fetch sequencer; stall/redirect/redirect_pc in, imem_addr/imem_instr memory side, instr/instr_pc/pc_plus4/instr_valid to decode, fault/fault_pc/fetch_count status
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int MEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);
    typedef enum logic [1:0] {FILL, RUN, FAULT} state_t;
    state_t state, state_n;
    logic [31:0] f_pc, d_pc, sel_pc, tgt;
    logic take, go, bad, consume;
    always_comb begin
        take = state == RUN && redirect;
        go = state == FILL || take || (state == RUN && !stall);
        consume = state == RUN && (redirect || !stall);
        tgt = take ? redirect_pc : f_pc;
        bad = tgt[1:0] != 2'b00 || tgt[31:2] >= 30'(MEM_WORDS);
        state_n = !go ? state : bad ? FAULT : RUN;
        // stalled or faulted: re-read the displayed word so instr stays stable
        sel_pc = (state == FAULT || (state == RUN && stall && !redirect)) ? d_pc : tgt;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            f_pc <= RESET_PC;
            d_pc <= RESET_PC;
            fault_pc <= '0;
            fetch_count <= '0;
        end else begin
            state <= state_n;
            if (consume)
                fetch_count <= fetch_count + 32'd1;
            if (go && bad)
                fault_pc <= tgt;
            else if (go) begin
                d_pc <= tgt;
                f_pc <= tgt + 32'd4;
            end
        end
    end
    assign imem_addr = {2'b00, sel_pc[31:2]};
    assign instr_valid = state == RUN;
    assign instr = instr_valid ? imem_instr : '0;
    assign instr_pc = d_pc;
    assign pc_plus4 = d_pc + 32'd4;
    assign fault = state == FAULT;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a PC-sequence reference model
module tb_fetch_unit;
    localparam int MW = 128;
    logic clk = 0, reset = 1, stall = 0, redirect = 0;
    logic [31:0] redirect_pc = 0, imem_addr, imem_instr, instr, instr_pc, pc_plus4, fault_pc, fetch_count;
    logic instr_valid, fault;
    logic [31:0] mem [MW];

    always #5 clk = ~clk;
    always @(posedge clk) imem_instr <= (imem_addr < MW) ? mem[imem_addr[6:0]] : 32'hDEAD_BEEF;

    fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_instr(imem_instr), .instr(instr), .instr_pc(instr_pc),
        .pc_plus4(pc_plus4), .instr_valid(instr_valid), .fault(fault), .fault_pc(fault_pc),
        .fetch_count(fetch_count)
    );

    typedef struct {
        logic v;
        logic [31:0] pc, ins, fpc, cnt;
        logic f;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, passed = 0;

    // reference model: what decode should be looking at after each edge
    bit m_valid = 0, m_fault = 0;
    logic [31:0] m_cur = 0, m_next = 0, m_fpc = 0, m_cnt = 0;

    task automatic deliver(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a / 4 >= MW) begin
            m_fault = 1;
            m_valid = 0;
            m_fpc = a;
        end else begin
            m_cur = a;
            m_next = a + 4;
            m_valid = 1;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit d, input logic [31:0] rpc);
        @(negedge clk);
        reset = r;
        stall = s;
        redirect = d;
        redirect_pc = rpc;
        if (r) begin
            m_valid = 0; m_fault = 0; m_cur = 0; m_next = 0; m_fpc = 0; m_cnt = 0;
        end else if (m_fault) begin
        end else if (!m_valid) deliver(m_next);
        else if (d) begin
            m_cnt++;
            deliver(rpc);
        end else if (!s) begin
            m_cnt++;
            deliver(m_next);
        end
        q.push_back('{m_valid, m_cur, m_valid ? mem[m_cur[8:2]] : 32'h0, m_fpc, m_cnt, m_fault});
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a === x) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("instr_valid", 32'(instr_valid), 32'(e.v));
            chk("fault", 32'(fault), 32'(e.f));
            chk("instr_pc", instr_pc, e.pc);
            chk("pc_plus4", pc_plus4, e.pc + 4);
            chk("instr", instr, e.ins);
            chk("fault_pc", fault_pc, e.fpc);
            chk("fetch_count", fetch_count, e.cnt);
        end
    end

    initial begin
        for (int i = 0; i < MW; i++) mem[i] = $urandom;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (7) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h40);
        repeat (2) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(0, 1, 1, 32'h40);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h42);
        step(0, 1, 0, 0);
        step(0, 0, 1, 32'h10);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h1F0);
        repeat (5) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        repeat (1500) begin
            int k;
            logic [31:0] t;
            k = $urandom_range(0, 9);
            t = k < 6 ? {23'd0, 7'($urandom_range(0, MW - 1)), 2'b00}
              : k == 6 ? {23'd0, 7'($urandom_range(0, MW - 1)), 2'($urandom_range(1, 3))}
              : k == 7 ? 32'($urandom_range(MW, MW + 64)) * 4
              : 32'h1F0 + 32'($urandom_range(0, 3)) * 4;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, t);
        end
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
